// File: rtl/limb_serial_addsub.sv
// Serial 256-bit add/subtract: one LIMB_W-bit limb per clock, LSB limb first,
// with the inter-limb carry/borrow held in a register and valid/ready on both sides.
module limb_serial_addsub #(
  parameter int LIMB_W = 64,
  parameter int LIMBS  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      op_sub,
  input  logic [LIMB_W*LIMBS-1:0]   a,
  input  logic [LIMB_W*LIMBS-1:0]   b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LIMB_W*LIMBS-1:0]   result,
  output logic                      carry_out,
  output logic                      zero
);

  localparam int W     = LIMB_W * LIMBS;
  localparam int CNT_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(LIMBS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic [LIMBS-1:0][LIMB_W-1:0]   r_a;
  logic [LIMBS-1:0][LIMB_W-1:0]   r_b;
  logic                           r_op_sub;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_carry;
  logic [LIMBS-1:0][LIMB_W-1:0]   r_result;
  logic                           r_carry_out;
  logic                           r_zero;

  logic [LIMB_W-1:0]              w_b_eff;
  logic [LIMB_W:0]                w_sum;
  logic [LIMBS-1:0][LIMB_W-1:0]   w_result_next;
  logic                           w_last;
  logic                           w_zero;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_next = S_RUN;
        else          w_state_next = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
        else        w_state_next = S_RUN;
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
        else           w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // One limb of the sum; subtraction is A + ~B with the carry seeded to 1.
  always_comb begin
    w_last = (r_cnt == LAST_LIMB);
    if (r_op_sub) w_b_eff = ~r_b[r_cnt];
    else          w_b_eff = r_b[r_cnt];
    w_sum = {1'b0, r_a[r_cnt]} + {1'b0, w_b_eff} + {{LIMB_W{1'b0}}, r_carry};
    w_result_next        = r_result;
    w_result_next[r_cnt] = w_sum[LIMB_W-1:0];
    w_zero = (w_result_next == {W{1'b0}});
  end

  // Operand capture and limb-serial datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a         <= {W{1'b0}};
      r_b         <= {W{1'b0}};
      r_op_sub    <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_carry     <= 1'b0;
      r_result    <= {W{1'b0}};
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_op_sub <= op_sub;
            r_cnt    <= {CNT_W{1'b0}};
            r_carry  <= op_sub;
          end
        end
        S_RUN: begin
          r_result <= w_result_next;
          r_carry  <= w_sum[LIMB_W];
          r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (w_last) begin
            r_carry_out <= r_op_sub ? ~w_sum[LIMB_W] : w_sum[LIMB_W];
            r_zero      <= w_zero;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign zero      = r_zero;

endmodule

// File: tb/tb_limb_serial_addsub.sv
// Bench for limb_serial_addsub: directed vector table, corner-case sequences,
// and randomized operations checked against a whole-word arithmetic model.
module tb_limb_serial_addsub;

  localparam int LIMB_W = 64;
  localparam int LIMBS  = 4;
  localparam int W      = LIMB_W * LIMBS;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  limb_serial_addsub #(.LIMB_W(LIMB_W), .LIMBS(LIMBS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .zero(zero)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: whole-word arithmetic, borrow is simply A < B.
  function automatic void ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rsub,
                                    output logic [W-1:0] rr, output logic rc, output logic rz);
    logic [W:0] t;
    if (rsub) begin
      t  = {1'b0, ra} - {1'b0, rb};
      rc = (ra < rb);
    end else begin
      t  = {1'b0, ra} + {1'b0, rb};
      rc = t[W];
    end
    rr = t[W-1:0];
    rz = (rr == {W{1'b0}});
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    for (int l = 0; l < LIMBS; l++) begin
      case ($urandom_range(0, 3))
        0:       v[l*LIMB_W +: LIMB_W] = {LIMB_W{1'b0}};
        1:       v[l*LIMB_W +: LIMB_W] = {LIMB_W{1'b1}};
        default: v[l*LIMB_W +: LIMB_W] = {$urandom, $urandom};
      endcase
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, wait for out_valid; optionally scramble inputs while busy.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub,
                        input bit scramble, output int lat);
    int guard;
    a = ta; b = tb_v; op_sub = tsub; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!in_ready) chk1("accept_timeout", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk1("in_ready_busy", in_ready, 1'b0);
      if (scramble) begin
        a = rnd_word(); b = rnd_word();
        op_sub = 1'($urandom); in_valid = 1'($urandom);
      end
      step();
      lat++;
    end
    chk1("in_ready_done", in_ready, 1'b0);
  endtask

  task automatic release_out();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk1("out_valid_after_ack", out_valid, 1'b0);
    chk1("in_ready_after_ack", in_ready, 1'b1);
  endtask

  initial begin
    vec_t         vecs[6];
    int           lat;
    logic [W-1:0] er, held;
    logic         ec, ez;

    vecs[0] = '{a: 256'd5, b: 256'd3, sub: 1'b0, r: 256'd8, c: 1'b0, z: 1'b0};
    vecs[1] = '{a: {256{1'b1}}, b: 256'd1, sub: 1'b0, r: 256'd0, c: 1'b1, z: 1'b1};
    vecs[2] = '{a: {192'd1, 64'd0}, b: 256'd1, sub: 1'b1, r: {192'd0, {64{1'b1}}}, c: 1'b0, z: 1'b0};
    vecs[3] = '{a: 256'd3, b: 256'd7, sub: 1'b1, r: ~256'd3, c: 1'b1, z: 1'b0};
    vecs[4] = '{a: 256'h1234, b: 256'h1234, sub: 1'b1, r: 256'd0, c: 1'b0, z: 1'b1};
    vecs[5] = '{a: {64'd0, {192{1'b1}}}, b: 256'd1, sub: 1'b0, r: {63'd0, 1'b1, 192'd0}, c: 1'b0, z: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
    a = {W{1'b0}}; b = {W{1'b0}};
    step(); step();
    rst_n = 1'b1;
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", result, {W{1'b0}});
    chk1("reset_carry_out", carry_out, 1'b0);
    chk1("reset_zero", zero, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0, lat);
      chki($sformatf("vec%0d_latency", i), lat, LIMBS);
      chk($sformatf("vec%0d_result", i), result, vecs[i].r);
      chk1($sformatf("vec%0d_carry", i), carry_out, vecs[i].c);
      chk1($sformatf("vec%0d_zero", i), zero, vecs[i].z);
      release_out();
    end

    // Backpressure: hold DONE for 10 cycles while a new op waits on the inputs.
    run_op(256'h0123_4567_89AB_CDEF_0000_0000_0000_0001, ~256'd0, 1'b0, 1'b1, lat);
    ref_model(256'h0123_4567_89AB_CDEF_0000_0000_0000_0001, ~256'd0, 1'b0, er, ec, ez);
    chki("bp_latency", lat, LIMBS);
    a = 256'd100; b = 256'd1; op_sub = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("bp_result_hold", result, er);
      chk1("bp_carry_hold", carry_out, ec);
      chk1("bp_out_valid_hold", out_valid, 1'b1);
      step();
    end
    held = result;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk1("bp_idle_after_ack", in_ready, 1'b1);
    chk("bp_result_kept_idle", result, held);
    chk1("bp_carry_kept_idle", carry_out, ec);
    run_op(256'd100, 256'd1, 1'b1, 1'b0, lat);
    chk("bp_next_result", result, 256'd99);
    chk1("bp_next_carry", carry_out, 1'b0);
    release_out();

    // Reset while the counter sits at limb 2.
    a = ~256'd0; b = 256'd5; op_sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_result", result, {W{1'b0}});
    step(); step();
    chk1("midrst_no_output", out_valid, 1'b0);
    run_op(256'd10, 256'd20, 1'b0, 1'b0, lat);
    chki("midrst_latency", lat, LIMBS);
    chk("midrst_next_result", result, 256'd30);
    chk1("midrst_next_zero", zero, 1'b0);
    release_out();

    // Randomized operations against the model, with input scrambling while busy.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = rnd_word(); rb = (n % 7 == 0) ? ra : rnd_word(); rs = 1'($urandom);
      ref_model(ra, rb, rs, er, ec, ez);
      run_op(ra, rb, rs, 1'b1, lat);
      chki("rnd_latency", lat, LIMBS);
      chk($sformatf("rnd%0d_result", n), result, er);
      chk1($sformatf("rnd%0d_carry", n), carry_out, ec);
      chk1($sformatf("rnd%0d_zero", n), zero, ez);
      release_out();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
